router_fifo: RTL and testbench
==============================

// Module: router_fifo
// PURPOSE
//  Per-destination output FIFO of the 1x3 packet router; one instance per output port.
//  Stores packet bytes (header, payload, parity) with a header-marker bit alongside each byte.
//  Tracks the current packet length while draining, and tri-states data_out once the
//  packet's last byte has been read.
//  Sits between the router's register/FSM write side and the destination read port.
// PARAMETERS
//  WIDTH     8   data byte width (stored word is WIDTH+1 bits: {hdr_flag, data})
//  DEPTH     16  number of FIFO entries
//  ADD_WIDTH 4   address bits (log2 DEPTH); pointers are ADD_WIDTH+1 bits wide
// PORTS
//  clock       in   1      single system clock, all state updates on posedge
//  resetn      in   1      asynchronous, active-low reset
//  soft_reset  in   1      synchronous flush (destination timeout), active-high
//  write_enb   in   1      write request
//  read_enb    in   1      read request
//  lfd_state   in   1      "load first data": high while the header byte is presented
//  data_in     in   WIDTH  byte to write
//  data_out    out  WIDTH  read byte; high-Z when no packet is being drained
//  empty       out  1      combinational, wr_ptr == rd_ptr
//  full        out  1      combinational, wr_ptr == {~rd_ptr[MSB], rd_ptr[ADD_WIDTH-1:0]}
// BEHAVIOUR
//  - resetn=0 (async):
//    - wr_ptr, rd_ptr, count, temp -> 0
//    - all fifo_mem -> 0
//    - data_out -> 0
//  - soft_reset=1 at posedge:
//    - pointers, count, temp and fifo_mem -> 0
//    - data_out -> 'z
//    - soft_reset overrides read and write in the same cycle
//  - temp: register sampling lfd_state every posedge (1-cycle delay), so the header byte,
//    written the cycle after lfd_state rises, is tagged.
//  - Write: write_enb && !full
//    - fifo_mem[wr_ptr[ADD_WIDTH-1:0]] <= {temp, data_in}
//    - wr_ptr++ (wraps modulo 2*DEPTH)
//    - Writes while full are dropped; no pointer change.
//  - Read: read_enb && !empty
//    - data_out <= fifo_mem[rd_ptr][WIDTH-1:0]; rd_ptr++ (1-cycle read latency)
//    - If the word's hdr_flag=1: count <= data[7:2] + 1 (payload length + parity).
//    - Else if count != 0: count <= count - 1.
//  - Read with read_enb && empty: no pointer change; data_out follows the rule below.
//  - data_out when not reading: 'z if count == 0, else holds its last value.
//  - Simultaneous read and write (not full, not empty): both occur in one cycle.
//  - count: 7 bits, never underflows.
//  - full and empty are never asserted together.
// STRUCTURE
//  - Internal names used by the bench's hierarchical probes:
//    - fifo_mem [0:DEPTH-1][WIDTH:0]
//    - wr_ptr, rd_ptr [ADD_WIDTH:0]
//    - temp, count
//  - Shared router package: WIDTH/DEPTH/ADD_WIDTH defaults, hdr_flag bit index,
//    length field slice [7:2].
//  - Single flat module; no sub-modules.
// TESTING
//  - Reset: resetn low 1 cycle
//    -> empty=1, full=0, data_out=0, pointers 0, all mem words 0.
//  - Header 0x45 (len 17, addr 01) with lfd_state=1, then 17 payload bytes and parity,
//    write_enb held throughout:
//    -> first 16 stored, mem[0][8]=1, full=1 after 16th write, last 3 bytes dropped.
//  - Read until empty:
//    -> data_out=0x45, count=18, then 15 bytes in write order; empty=1 after 16 reads.
//  - Short packet (header len 2, 2 payload bytes, parity), read fully
//    -> count reaches 0, data_out='z the cycle after the parity byte.
//  - Simultaneous read/write at 8 entries occupied -> occupancy stays 8, pointers both advance.
//  - soft_reset mid-packet
//    -> next cycle empty=1, data_out='z, count=0; resetn mid-write clears immediately (async).

Source files
------------

// File: rtl/router_fifo_pkg.sv
// rtl/router_fifo_pkg.sv - shared router constants for the per-destination output FIFO
package router_fifo_pkg;

    localparam int FIFO_WIDTH     = 8;
    localparam int FIFO_DEPTH     = 16;
    localparam int FIFO_ADD_WIDTH = 4;

    // Stored word is {hdr_flag, data}; the flag sits just above the data byte.
    localparam int HDR_BIT = FIFO_WIDTH;

    // Header byte carries the payload length in [7:2] and the destination in [1:0].
    localparam int LEN_MSB = 7;
    localparam int LEN_LSB = 2;
    localparam int CNT_W   = 7;

    function automatic logic [CNT_W-1:0] drain_count(input logic [LEN_MSB-LEN_LSB:0] len);
        return {1'b0, len} + 7'd1;
    endfunction

endpackage

// File: rtl/router_fifo.sv
// rtl/router_fifo.sv - per-destination packet FIFO with header tagging and drain-length tracking
module router_fifo
    import router_fifo_pkg::*;
#(
    parameter int WIDTH     = FIFO_WIDTH,
    parameter int DEPTH     = FIFO_DEPTH,
    parameter int ADD_WIDTH = FIFO_ADD_WIDTH
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             read_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             empty,
    output logic             full
);

    localparam logic [ADD_WIDTH:0] PTR_ONE = 1;

    logic [WIDTH:0]     fifo_mem [0:DEPTH-1];
    logic [ADD_WIDTH:0] wr_ptr;
    logic [ADD_WIDTH:0] rd_ptr;
    logic               temp;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   data_q;
    logic               drive_en;

    logic               wr_go;
    logic               rd_go;
    logic [WIDTH:0]     rd_word;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr == {~rd_ptr[ADD_WIDTH], rd_ptr[ADD_WIDTH-1:0]});
    assign wr_go   = write_enb && !full;
    assign rd_go   = read_enb && !empty;
    assign rd_word = fifo_mem[rd_ptr[ADD_WIDTH-1:0]];

    // The header is written one cycle after lfd_state, so the delayed copy tags it.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            temp <= 1'b0;
        end else if (soft_reset) begin
            temp <= 1'b0;
        end else begin
            temp <= lfd_state;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) fifo_mem[i] <= '0;
        end else if (soft_reset) begin
            for (int i = 0; i < DEPTH; i++) fifo_mem[i] <= '0;
        end else if (wr_go) begin
            fifo_mem[wr_ptr[ADD_WIDTH-1:0]] <= {temp, data_in};
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            data_q   <= '0;
            drive_en <= 1'b1;
        end else if (soft_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            data_q   <= '0;
            drive_en <= 1'b0;
        end else begin
            if (wr_go) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_go) begin
                rd_ptr   <= rd_ptr + PTR_ONE;
                data_q   <= rd_word[WIDTH-1:0];
                drive_en <= 1'b1;
                if (rd_word[HDR_BIT]) begin
                    count <= drain_count(rd_word[LEN_MSB:LEN_LSB]);
                end else if (count != '0) begin
                    count <= count - 7'd1;
                end
            end else if (count == '0) begin
                // Packet fully drained: release the destination bus.
                drive_en <= 1'b0;
            end
        end
    end

    assign data_out = drive_en ? data_q : 'z;

endmodule

// File: tb/tb_router_fifo.sv
// tb/tb_router_fifo.sv - scoreboard bench for router_fifo
module tb_router_fifo;

    logic       clock = 1'b0;
    logic       resetn;
    logic       soft_reset;
    logic       write_enb;
    logic       read_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    wire  [7:0] data_out;
    logic       empty;
    logic       full;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] sb_q [$];
    logic [7:0] pkt [0:18];
    logic [7:0] zv;
    logic [7:0] par;
    int         nz;

    router_fifo dut (
        .clock      (clock),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .data_out   (data_out),
        .empty      (empty),
        .full       (full)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: drive one cycle, update the model, compare any read data.
    task automatic cycle(input logic wr, input logic rd, input logic lfd, input logic [7:0] din);
        logic       rd_ok;
        logic       wr_ok;
        logic [7:0] exp;
        write_enb = wr;
        read_enb  = rd;
        lfd_state = lfd;
        data_in   = din;
        rd_ok = rd && (sb_q.size() != 0);
        wr_ok = wr && (sb_q.size() != 16);
        exp   = 8'h00;
        if (rd_ok) exp = sb_q.pop_front();
        if (wr_ok) sb_q.push_back(din);
        @(posedge clock);
        @(negedge clock);
        if (rd_ok) check("rd_data", {24'h0, data_out}, {24'h0, exp});
        write_enb = 1'b0;
        read_enb  = 1'b0;
        lfd_state = 1'b0;
    endtask

    initial begin
        zv = 'z;
        resetn = 1'b0; soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
        lfd_state = 1'b0; data_in = 8'h00;
        @(negedge clock);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_data_out", {24'h0, data_out}, 32'h0);
        check("rst_wr_ptr", dut.wr_ptr, 0);
        check("rst_rd_ptr", dut.rd_ptr, 0);
        nz = 0;
        for (int i = 0; i < 16; i++) if (dut.fifo_mem[i] != 9'h0) nz++;
        check("rst_mem_nonzero", nz, 0);
        resetn = 1'b1;
        @(negedge clock);

        // Long packet: header 0x45 + 17 payload + parity, overflows the 16-entry FIFO.
        pkt[0] = 8'h45;
        par = 8'h45;
        for (int i = 1; i <= 17; i++) begin
            pkt[i] = 8'(i * 7 + 3);
            par = par ^ pkt[i];
        end
        pkt[18] = par;
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 19; i++) begin
            cycle(1'b1, 1'b0, 1'b0, pkt[i]);
            if (i == 14) check("full_before_16", full, 0);
            if (i == 15) check("full_after_16", full, 1);
        end
        check("ovf_wr_ptr", dut.wr_ptr, 16);
        check("ovf_empty", empty, 0);
        check("hdr_flag_mem0", dut.fifo_mem[0][8], 1);
        check("hdr_flag_mem1", dut.fifo_mem[1][8], 0);
        check("mem15_data", dut.fifo_mem[15][7:0], pkt[15]);

        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 8'h00);
            if (i == 0) check("hdr_count", dut.count, 18);
        end
        check("drain_empty", empty, 1);
        check("drain_full", full, 0);
        check("drain_count", dut.count, 3);
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        check("rd_empty_rd_ptr", dut.rd_ptr, 16);
        check("rd_empty_hold", {24'h0, data_out}, {24'h0, pkt[15]});
        check("rd_empty_drive", dut.drive_en, 1);

        // Short packet: length 2, then the bus floats after the parity byte.
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        cycle(1'b1, 1'b0, 1'b0, 8'h09);
        cycle(1'b1, 1'b0, 1'b0, 8'hA1);
        cycle(1'b1, 1'b0, 1'b0, 8'hA2);
        cycle(1'b1, 1'b0, 1'b0, 8'h09 ^ 8'hA1 ^ 8'hA2);
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        check("short_hdr_count", dut.count, 3);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
        check("short_count_zero", dut.count, 0);
        check("short_parity_drive", dut.drive_en, 1);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        check("short_float_en", dut.drive_en, 0);
        check("short_float_z", {24'h0, data_out}, {24'h0, zv});

        // Concurrent read/write with 8 entries resident; write pointer wraps.
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 8'h50 + 8'(i));
        check("rw_pre_wr_ptr", dut.wr_ptr, 28);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 8'hC0 + 8'(i));
        check("rw_wr_ptr", dut.wr_ptr, 0);
        check("rw_rd_ptr", dut.rd_ptr, 24);
        check("rw_not_empty", empty, 0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
        check("rw_drained", empty, 1);

        // Soft reset mid-packet overrides a simultaneous read and write.
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        cycle(1'b1, 1'b0, 1'b0, 8'h0D);
        cycle(1'b1, 1'b0, 1'b0, 8'h11);
        cycle(1'b1, 1'b0, 1'b0, 8'h12);
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        check("sr_pre_count", dut.count, 4);
        soft_reset = 1'b1; write_enb = 1'b1; read_enb = 1'b1; data_in = 8'hEE;
        @(posedge clock);
        @(negedge clock);
        soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
        sb_q.delete();
        check("sr_empty", empty, 1);
        check("sr_count", dut.count, 0);
        check("sr_data_z", {24'h0, data_out}, {24'h0, zv});
        check("sr_drive_en", dut.drive_en, 0);
        check("sr_wr_ptr", dut.wr_ptr, 0);
        check("sr_rd_ptr", dut.rd_ptr, 0);
        check("sr_mem1", dut.fifo_mem[1], 0);

        // Asynchronous reset in the middle of a write cycle.
        cycle(1'b1, 1'b0, 1'b0, 8'h31);
        cycle(1'b1, 1'b0, 1'b0, 8'h32);
        write_enb = 1'b1; data_in = 8'h33;
        #2;
        resetn = 1'b0;
        #1;
        check("ar_wr_ptr", dut.wr_ptr, 0);
        check("ar_empty", empty, 1);
        check("ar_data_out", {24'h0, data_out}, 32'h0);
        check("ar_mem0", dut.fifo_mem[0], 0);
        @(negedge clock);
        write_enb = 1'b0;
        resetn = 1'b1;
        sb_q.delete();
        @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
